alu_share_arbiter: RTL and testbench

//  Shares the single 16-bit combinational ALU between two requesters: port 0 (execute stage) and port 1 (address/branch unit).

---
 rtl/alu_share_arbiter_pkg.sv | 18 +
 rtl/alu_share_arbiter_if.sv | 35 +++
 rtl/alu_share_arbiter_rr_arb2.sv | 19 +
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 tb/tb_alu_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared definitions for the ALU sharing arbiter: ALU opcode encodings and
//   the arbiter FSM state type.
package alu_share_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b111;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Request/response channels between the two ALU requesters and the arbiter.
//   Bit i / slice i of every two-port field belongs to port i, packed {p1,p0}.
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side
//   req_valid/req_ready   per-port request handshake
//   req_op/req_a/req_b    per-port opcode and operands
//   req_setflag           per-port: update Z/N from this operation
//   rsp_valid/rsp_ready   per-port response handshake
//   rsp_r/rsp_z/rsp_n     shared result bus and architectural flags
interface alu_share_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [5:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         req_setflag;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_r;
  logic               rsp_z;
  logic               rsp_n;

  modport master (
    output req_valid, req_op, req_a, req_b, req_setflag, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_z, rsp_n
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_setflag, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_z, rsp_n
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant selection.
//   req   : per-port request
//   last  : port granted most recently
//   grant : selected port (valid when any=1)
//   any   : at least one request present
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);
  always_comb begin
    any = |req;
    // On a tie the port not served last wins; otherwise the lone requester.
    if (&req) grant = ~last;
    else      grant = req[1];
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between port 0 (execute stage) and
//   port 1 (address/branch unit). One operation in flight at a time:
//   IDLE (grant + latch operands) -> EXEC (drive ALU, capture result/flags)
//   -> RESP (present result until the granted port takes it).
//   clk, rst    : clock, synchronous active-high reset
//   bus         : request/response channels (slave side)
//   alu_a/alu_b/alu_op/alu_en/alu_setflag : drive the external ALU
//   alu_r/alu_z/alu_n                     : ALU result and compare flags
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  output logic               alu_en,
  output logic               alu_setflag,
  input  logic [WIDTH-1:0]   alu_r,
  input  logic               alu_z,
  input  logic               alu_n
);

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             setflag_q;
  logic             g_q;
  logic             last_grant;
  logic             z_q, n_q;
  logic             grant, any, accept;

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    alu_en        = 1'b0;
    alu_setflag   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any) begin
          accept               = 1'b1;
          bus.req_ready[grant] = 1'b1;
          state_nxt            = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en      = 1'b1;
        alu_setflag = setflag_q;
        state_nxt   = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid[g_q] = 1'b1;
        if (bus.rsp_ready[g_q]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      setflag_q  <= 1'b0;
      g_q        <= 1'b0;
      last_grant <= 1'b1;
      res_q      <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= grant ? bus.req_op[5:3] : bus.req_op[2:0];
        a_q       <= grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        b_q       <= grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        setflag_q <= bus.req_setflag[grant];
        g_q       <= grant;
      end
      if (state == S_EXEC) begin
        res_q      <= alu_r;
        last_grant <= g_q;
        if (setflag_q) begin
          z_q <= alu_z;
          n_q <= alu_n;
        end
      end
    end
  end

  // ALU inputs come straight from the operand registers so they only move
  // when a new request is latched.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign bus.rsp_r = res_q;
  assign bus.rsp_z = z_q;
  assign bus.rsp_n = n_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter. Stands in for the external ALU, runs directed
//   scenarios and a randomized phase, and keeps a transaction-level model
//   (one outstanding op, round-robin tie rule, flag pair) that predicts every
//   handshake and output each cycle.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic [2:0]   alu_op;
  logic         alu_en, alu_setflag, alu_z, alu_n;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter_if #(.WIDTH(W)) bus ();

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_en      (alu_en),
    .alu_setflag (alu_setflag),
    .alu_r       (alu_r),
    .alu_z       (alu_z),
    .alu_n       (alu_n)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOT:  return ~a;
      default: return '0;
    endcase
  endfunction

  // External ALU stand-in: combinational, flags from an unsigned compare.
  always_comb begin
    alu_r = alu_ref(alu_op, alu_a, alu_b);
    alu_z = (alu_a == alu_b);
    alu_n = (alu_a < alu_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           port;
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic         sf, z, n;
  } txn_t;

  txn_t cur = '{0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0};
  bit   m_ok = 1'b0;
  bit   busy = 1'b0;
  int   age = 0;
  int   last_g = 1;
  logic mz = 1'b0, mn = 1'b0;
  int   grants[$];

  always @(negedge clk) begin
    logic [1:0] v, exp_ready, exp_rv;
    int g;
    v = bus.req_valid;
    g = 0;
    if (v == 2'b11) g = 1 - last_g;
    else if (v[1]) g = 1;
    exp_ready = (!busy && v != 2'b00) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
    exp_rv    = (busy && age >= 2) ? ((cur.port == 1) ? 2'b10 : 2'b01) : 2'b00;
    if (m_ok) begin
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      check_eq("rsp_z", 32'(bus.rsp_z), 32'(mz));
      check_eq("rsp_n", 32'(bus.rsp_n), 32'(mn));
      check_eq("alu_en", 32'(alu_en), 32'(busy && age == 1));
      check_eq("alu_setflag", 32'(alu_setflag), 32'(busy && age == 1 && cur.sf));
      check_eq("alu_a", 32'(alu_a), 32'(cur.a));
      check_eq("alu_b", 32'(alu_b), 32'(cur.b));
      check_eq("alu_op", 32'(alu_op), 32'(cur.op));
      if (exp_rv != 2'b00) check_eq("rsp_r", 32'(bus.rsp_r), 32'(cur.r));
    end
    if (rst) begin
      busy   = 1'b0;
      age    = 0;
      last_g = 1;
      mz     = 1'b0;
      mn     = 1'b0;
      cur    = '{0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0};
      m_ok   = 1'b1;
    end else if (busy) begin
      if (exp_rv != 2'b00 && bus.rsp_ready[cur.port]) begin
        busy = 1'b0;
      end else begin
        if (age == 1) begin
          mz = cur.z;
          mn = cur.n;
        end
        age++;
      end
    end else if (exp_ready != 2'b00) begin
      cur.port = g;
      cur.op   = (g == 1) ? bus.req_op[5:3] : bus.req_op[2:0];
      cur.a    = (g == 1) ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
      cur.b    = (g == 1) ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
      cur.sf   = bus.req_setflag[g];
      cur.r    = alu_ref(cur.op, cur.a, cur.b);
      cur.z    = cur.sf ? (cur.a == cur.b) : mz;
      cur.n    = cur.sf ? (cur.a < cur.b) : mn;
      busy     = 1'b1;
      age      = 1;
      last_g   = g;
      grants.push_back(g);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sf);
    if (p == 1) begin
      bus.req_op[5:3]     = op;
      bus.req_a[2*W-1:W]  = a;
      bus.req_b[2*W-1:W]  = b;
      bus.req_setflag[1]  = sf;
    end else begin
      bus.req_op[2:0]     = op;
      bus.req_a[W-1:0]    = a;
      bus.req_b[W-1:0]    = b;
      bus.req_setflag[0]  = sf;
    end
  endtask

  task automatic rand_req(input int p);
    logic [W-1:0] a, b;
    case ($urandom_range(0, 3))
      0:       a = '0;
      1:       a = '1;
      default: a = W'($urandom);
    endcase
    b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
    set_req(p, 3'($urandom), a, b, 1'($urandom));
  endtask

  // Called just after a rising edge. Issues one request on port p, checks the
  // two-cycle response latency and the response contents, optionally keeps
  // rsp_ready low for `hold` RESP cycles, and raises port 1 during EXEC.
  task automatic do_op(input string tag, input int p, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic sf,
                       input logic [W-1:0] er, input logic ez, input logic en,
                       input int hold, input bit raise1);
    logic [1:0] oh;
    bit acc;
    int cyc;
    oh = (p == 1) ? 2'b10 : 2'b01;
    set_req(p, op, a, b, sf);
    bus.req_valid[p] = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = bus.req_ready[p];
      cyc++;
    end
    check_eq({tag, "_accept"}, 32'(acc), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[p] = 1'b0;
    if (!acc) return;
    if (raise1) bus.req_valid[1] = 1'b1;
    @(negedge clk);
    check_eq({tag, "_exec_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'(oh));
      check_eq({tag, "_hold_r"}, 32'(bus.rsp_r), 32'(er));
      @(posedge clk); #1;
    end
    bus.rsp_ready[p] = 1'b1;
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'(oh));
    check_eq({tag, "_r"}, 32'(bus.rsp_r), 32'(er));
    check_eq({tag, "_z"}, 32'(bus.rsp_z), 32'(ez));
    check_eq({tag, "_n"}, 32'(bus.rsp_n), 32'(en));
    @(posedge clk); #1;
    bus.rsp_ready[p] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] acc;
    int cyc;
    bit ok;
    bus.req_valid   = '0;
    bus.req_op      = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_setflag = '0;
    bus.rsp_ready   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_r", 32'(bus.rsp_r), 32'd0);
    check_eq("rst_rsp_zn", 32'({bus.rsp_z, bus.rsp_n}), 32'd0);
    check_eq("rst_alu_ctl", 32'({alu_en, alu_setflag, alu_op}), 32'd0);
    check_eq("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    @(posedge clk); #1;

    do_op("t1_add", 0, OP_ADD, 16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    do_op("t2_sub", 1, OP_SUB, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    do_op("t2_or",  0, OP_OR,  16'h00F0, 16'h000F, 1'b0, 16'h00FF, 1'b1, 1'b0, 0, 1'b0);
    do_op("t4_wrap", 0, OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    do_op("t4_not", 0, OP_NOT, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 1'b1, 1'b0, 0, 1'b0);
    do_op("t4_undef", 1, 3'b011, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

    // Stall in RESP with port 1 waiting; port 1 must be taken right after.
    set_req(1, OP_ADD, 16'h0001, 16'h0001, 1'b0);
    do_op("t5_stall", 0, OP_AND, 16'h0F0F, 16'h00FF, 1'b0, 16'h000F, 1'b1, 1'b0, 5, 1'b1);
    @(negedge clk);
    check_eq("t5_p1_accept", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    bus.rsp_ready    = 2'b11;
    repeat (3) @(posedge clk);
    #1 bus.rsp_ready = 2'b00;

    // Reset while the op is in EXEC: dropped, flags back to zero.
    set_req(0, OP_SUB, 16'h0002, 16'h0009, 1'b1);
    bus.req_valid[0] = 1'b1;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 20) begin
      @(negedge clk);
      ok = bus.req_ready[0];
      cyc++;
    end
    check_eq("t6_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check_eq("t6_flags", 32'({bus.rsp_z, bus.rsp_n}), 32'd0);
    end
    @(posedge clk); #1;

    // Both ports continuously valid: grants must alternate starting at 0.
    grants.delete();
    rand_req(0);
    rand_req(1);
    bus.req_valid = 2'b11;
    cyc = 0;
    while (grants.size() < 6 && cyc < 100) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (acc[p]) rand_req(p);
      cyc++;
    end
    bus.req_valid = 2'b00;
    check_eq("t3_grant_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check_eq("t3_grant_order", 32'(grants[i]), 32'(i % 2));
    repeat (4) @(posedge clk);
    #1 bus.rsp_ready = 2'b00;

    // Randomized traffic, occasional resets and valid drops.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!bus.req_valid[p] || acc[p]) begin
          bus.req_valid[p] = ($urandom_range(0, 2) != 0);
          rand_req(p);
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[p] = 1'b0;
        end
      end
      bus.rsp_ready = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 149) == 0);
      if (rst) bus.req_valid = 2'b00;
    end

    rst           = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("drain_idle", 32'(bus.rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
